// File: rtl/readout_sequencer.sv
// readout_sequencer: snapshots the channel words on a trigger and emits the
// enabled channels byte by byte, each byte tagged with its SPI register address.
module readout_sequencer #(
    parameter int NUM_CH    = 8,
    parameter int CH_WIDTH  = 50,
    parameter int BASE_ADDR = 4
) (
    input  logic                       iclk,
    input  logic                       rstn,
    input  logic                       trigger,
    input  logic                       abort,
    input  logic [NUM_CH-1:0]          chan_mask,
    input  logic [NUM_CH*CH_WIDTH-1:0] ch_data,
    input  logic                       byte_ready,
    output logic                       byte_valid,
    output logic [7:0]                 byte_data,
    output logic [5:0]                 byte_addr,
    output logic                       busy,
    output logic                       done,
    output logic                       trig_dropped
);

    localparam int NB = (CH_WIDTH + 7) / 8;
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [NUM_CH*CH_WIDTH-1:0]  r_snap;
    logic [NUM_CH-1:0]           r_mask;
    logic [CW-1:0]               r_ch;
    logic [CW-1:0]               w_ch_nxt;
    logic [CW-1:0]               w_first_ch;
    logic [CW-1:0]               w_next_ch;
    logic                        w_has_next;
    logic [BW-1:0]               r_b;
    logic [BW-1:0]               w_b_nxt;
    logic                        w_capture;
    logic                        r_drop;
    logic [NB*8-1:0]             w_word;
    logic [31:0]                 w_addr_full;

    // Lowest enabled channel of the live mask (start point) and next enabled
    // channel above the current one in the captured mask (skip costs no cycle).
    always_comb begin
        w_first_ch = '0;
        w_next_ch  = '0;
        w_has_next = 1'b0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (chan_mask[c]) begin
                w_first_ch = CW'(c);
            end
            if (r_mask[c] && (c > int'(r_ch))) begin
                w_next_ch  = CW'(c);
                w_has_next = 1'b1;
            end
        end
    end

    // Next-state logic; abort takes priority over a transfer.
    always_comb begin
        w_state_nxt = r_state;
        w_ch_nxt    = r_ch;
        w_b_nxt     = r_b;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (trigger) begin
                    w_capture   = 1'b1;
                    w_ch_nxt    = w_first_ch;
                    w_b_nxt     = '0;
                    w_state_nxt = (chan_mask == '0) ? S_DONE : S_SEND;
                end
            end
            S_SEND: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (byte_ready) begin
                    if (r_b == BW'(NB - 1)) begin
                        if (w_has_next) begin
                            w_ch_nxt = w_next_ch;
                            w_b_nxt  = '0;
                        end else begin
                            w_state_nxt = S_DONE;
                        end
                    end else begin
                        w_b_nxt = r_b + 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge iclk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Channel/byte pointer, plus snapshot and mask captured only on an accepted trigger.
    always_ff @(posedge iclk or negedge rstn) begin
        if (!rstn) begin
            r_ch   <= '0;
            r_b    <= '0;
            r_snap <= '0;
            r_mask <= '0;
        end else begin
            r_ch <= w_ch_nxt;
            r_b  <= w_b_nxt;
            if (w_capture) begin
                r_snap <= ch_data;
                r_mask <= chan_mask;
            end
        end
    end

    // A trigger seen while busy is reported one cycle later.
    always_ff @(posedge iclk or negedge rstn) begin
        if (!rstn) begin
            r_drop <= 1'b0;
        end else begin
            r_drop <= trigger && (r_state != S_IDLE);
        end
    end

    // Output byte and address from registered pointer and snapshot only.
    always_comb begin
        w_word                 = '0;
        w_word[CH_WIDTH-1:0]   = r_snap[int'(r_ch)*CH_WIDTH +: CH_WIDTH];
        w_addr_full            = 32'(BASE_ADDR) + 32'(NB) * 32'(r_ch) + 32'(r_b);
        byte_valid             = (r_state == S_SEND);
        byte_data              = byte_valid ? w_word[8*int'(r_b) +: 8] : 8'h00;
        byte_addr              = byte_valid ? w_addr_full[5:0] : 6'd0;
        busy                   = (r_state != S_IDLE);
        done                   = (r_state == S_DONE) && !abort;
        trig_dropped           = r_drop;
    end

endmodule

// File: tb/tb_readout_sequencer.sv
// Directed bench for readout_sequencer: byte streams against a bench-side model
// of the snapshot, stalls, dropped triggers, abort, empty mask and reset.
module tb_readout_sequencer;

    localparam int NUM_CH   = 8;
    localparam int CH_WIDTH = 50;

    logic                       iclk;
    logic                       rstn;
    logic                       trigger;
    logic                       abort;
    logic [NUM_CH-1:0]          chan_mask;
    logic [NUM_CH*CH_WIDTH-1:0] ch_data;
    logic                       byte_ready;
    logic                       byte_valid;
    logic [7:0]                 byte_data;
    logic [5:0]                 byte_addr;
    logic                       busy;
    logic                       done;
    logic                       trig_dropped;

    logic [CH_WIDTH-1:0]        exp_words [NUM_CH];
    int                         n_chk;
    int                         n_pass;
    int                         dc;

    readout_sequencer #(
        .NUM_CH   (NUM_CH),
        .CH_WIDTH (CH_WIDTH),
        .BASE_ADDR(4)
    ) u_dut (
        .iclk        (iclk),
        .rstn        (rstn),
        .trigger     (trigger),
        .abort       (abort),
        .chan_mask   (chan_mask),
        .ch_data     (ch_data),
        .byte_ready  (byte_ready),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_addr   (byte_addr),
        .busy        (busy),
        .done        (done),
        .trig_dropped(trig_dropped)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] get_byte(input logic [CH_WIDTH-1:0] w, input int b);
        logic [55:0] x;
        x = 56'(w);
        return x[8*b +: 8];
    endfunction

    task automatic load_words();
        for (int c = 0; c < NUM_CH; c++) begin
            ch_data[c*CH_WIDTH +: CH_WIDTH] = exp_words[c];
        end
    endtask

    // One full readout: trigger, then check every cycle until done (bounded).
    task automatic do_readout(input logic [7:0] mask, input bit rnd_ready, input bit scramble,
                              input bit retrig, output int done_cyc);
        logic [7:0]  exp_addr [$];
        logic [7:0]  exp_data [$];
        logic [63:0] t;
        int          idx;
        int          cyc;
        bit          exp_drop;
        bit          trig_now;
        bit          seen_done;
        idx       = 0;
        exp_drop  = 1'b0;
        seen_done = 1'b0;
        done_cyc  = -1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (mask[c]) begin
                for (int b = 0; b < 7; b++) begin
                    exp_addr.push_back(8'(4 + 7*c + b));
                    exp_data.push_back(get_byte(exp_words[c], b));
                end
            end
        end
        @(negedge iclk);
        chan_mask  = mask;
        load_words();
        byte_ready = 1'b1;
        trigger    = 1'b1;
        @(negedge iclk);
        trigger = 1'b0;
        cyc     = 1;
        while (!seen_done && cyc < 2000) begin
            chk("trig_dropped", 64'(trig_dropped), 64'(exp_drop));
            chk("busy", 64'(busy), 64'd1);
            if (byte_valid) begin
                if (idx < exp_addr.size()) begin
                    chk("byte_addr", 64'(byte_addr), 64'(exp_addr[idx]));
                    chk("byte_data", 64'(byte_data), 64'(exp_data[idx]));
                end else begin
                    chk("extra_byte", 64'd1, 64'd0);
                end
            end
            if (done) begin
                seen_done = 1'b1;
                done_cyc  = cyc;
                chk("byte_count", 64'(idx), 64'(exp_addr.size()));
            end
            trig_now   = retrig && ((cyc % 4 == 0) || done);
            trigger    = trig_now;
            exp_drop   = trig_now;
            byte_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (byte_valid && byte_ready) idx++;
            if (scramble) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    t = {$urandom(), $urandom()};
                    ch_data[c*CH_WIDTH +: CH_WIDTH] = t[CH_WIDTH-1:0];
                end
                chan_mask = 8'($urandom());
            end
            @(negedge iclk);
            cyc++;
        end
        if (!seen_done) chk("done_timeout", 64'd0, 64'd1);
        chk("post_trig_dropped", 64'(trig_dropped), 64'(exp_drop));
        chk("post_busy", 64'(busy), 64'd0);
        chk("post_valid", 64'(byte_valid), 64'd0);
        chk("post_done", 64'(done), 64'd0);
        trigger    = 1'b0;
        byte_ready = 1'b1;
    endtask

    initial begin
        n_chk      = 0;
        n_pass     = 0;
        rstn       = 1'b0;
        trigger    = 1'b0;
        abort      = 1'b0;
        chan_mask  = '0;
        ch_data    = '0;
        byte_ready = 1'b0;
        for (int c = 0; c < NUM_CH; c++) exp_words[c] = 50'h3_0000_0000_0000 | 50'(c);

        repeat (2) @(negedge iclk);
        chk("rst_valid", 64'(byte_valid), 64'd0);
        chk("rst_data", 64'(byte_data), 64'd0);
        chk("rst_addr", 64'(byte_addr), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_drop", 64'(trig_dropped), 64'd0);
        rstn = 1'b1;

        // All channels, sink always ready.
        do_readout(8'hFF, 1'b0, 1'b0, 1'b0, dc);
        chk("all_done_cycle", 64'(dc), 64'd57);

        // Channels 1 and 7 only.
        do_readout(8'b1000_0010, 1'b0, 1'b0, 1'b0, dc);
        chk("sparse_done_cycle", 64'(dc), 64'd15);

        // Random stalls, live inputs scrambled after the trigger.
        for (int c = 0; c < NUM_CH; c++)
            exp_words[c] = 50'h2_5A5A_1234_9876 ^ (50'h1_0305_070B_0D11 * 50'(c + 1));
        do_readout(8'b0101_1001, 1'b1, 1'b1, 1'b0, dc);
        do_readout(8'b1111_0000, 1'b1, 1'b1, 1'b0, dc);

        // Triggers during SEND and in the DONE cycle are dropped.
        do_readout(8'b0000_0101, 1'b1, 1'b0, 1'b1, dc);
        do_readout(8'b0010_0000, 1'b0, 1'b0, 1'b1, dc);
        chk("retrig_done_cycle", 64'(dc), 64'd8);

        // Abort while byte 20 (channel 2, byte 6) is pending.
        for (int c = 0; c < NUM_CH; c++) exp_words[c] = 50'h3_0000_0000_0000 | 50'(c);
        @(negedge iclk);
        chan_mask  = 8'hFF;
        load_words();
        byte_ready = 1'b1;
        trigger    = 1'b1;
        @(negedge iclk);
        trigger = 1'b0;
        for (int k = 1; k < 21; k++) @(negedge iclk);
        chk("abort_pending_addr", 64'(byte_addr), 64'd24);
        chk("abort_pending_data", 64'(byte_data), 64'h03);
        abort = 1'b1;
        @(negedge iclk);
        abort = 1'b0;
        chk("abort_valid", 64'(byte_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        for (int k = 0; k < 3; k++) begin
            chk("abort_no_done", 64'(done), 64'd0);
            @(negedge iclk);
        end
        do_readout(8'b1000_0010, 1'b0, 1'b0, 1'b0, dc);
        chk("restart_done_cycle", 64'(dc), 64'd15);

        // Empty mask: done right away, no bytes.
        do_readout(8'h00, 1'b0, 1'b0, 1'b0, dc);
        chk("empty_done_cycle", 64'(dc), 64'd1);

        // Reset in the middle of SEND clears outputs immediately.
        @(negedge iclk);
        chan_mask = 8'hFF;
        load_words();
        trigger = 1'b1;
        @(negedge iclk);
        trigger = 1'b0;
        repeat (10) @(negedge iclk);
        chk("pre_rst_valid", 64'(byte_valid), 64'd1);
        rstn = 1'b0;
        #1;
        chk("midrst_valid", 64'(byte_valid), 64'd0);
        chk("midrst_data", 64'(byte_data), 64'd0);
        chk("midrst_addr", 64'(byte_addr), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_drop", 64'(trig_dropped), 64'd0);
        @(negedge iclk);
        rstn = 1'b1;
        do_readout(8'b0000_0001, 1'b0, 1'b0, 1'b0, dc);
        chk("after_rst_done_cycle", 64'(dc), 64'd8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
